anode_scan_driver: RTL and testbench

Time-multiplexed driver for the 8-digit seven-segment display: steps a scan index through digits 0..7 at a programmable rate and drives active-low anodes, segments and decimal point for one digit per slot. It also emits the active-high one-hot anode vector that `anode_decoder`-style consumers turn back into an index. It sits between the display data path (hex nibbles from the UART/TX status logic) and the board pins.

---
 rtl/anode_scan_driver.sv | 180 ++++++++++++++++++
 tb/tb_anode_scan_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/anode_scan_driver.sv
// ----------------------------------------------------------------------------
// anode_scan_driver
//
// Drives an 8-digit seven-segment display by time-multiplexing. One digit is
// lit per slot. Each slot lasts REFRESH_DIV clock cycles, and the scan visits
// digits 0..7 in a repeating frame. The digit data, enables and decimal points
// are copied into shadow registers once per frame, on the wrap from digit 7 to
// digit 0. Changing the inputs mid-frame therefore never tears the display.
//
// Optional feature macro: SCAN_BLANKING_EN
//   defined   : the first BLANK_CYCLES output cycles of every slot are dark
//               (anti-ghosting).
//   undefined : BLANK_CYCLES has no effect, and a lit digit turns on in the
//               same cycle as anode_onehot moves to it.
//
// Parameters
//   REFRESH_DIV  : clock cycles per digit slot (>= 2)
//   BLANK_CYCLES : dark cycles at the start of each slot (< REFRESH_DIV)
//
// Ports
//   clk          in   single rising-edge clock
//   rst          in   asynchronous active-high reset
//   digits_in    in   [31:0] eight hex nibbles, digit k = digits_in[4k+3:4k]
//   digit_en     in   [7:0]  bit k lights digit k
//   dp_in        in   [7:0]  bit k lights the decimal point of digit k
//   an           out  [7:0]  active-low anode drive, bit k = digit k
//   seg          out  [6:0]  active-low segments {g,f,e,d,c,b,a}
//   dp           out         active-low decimal point
//   anode_onehot out  [7:0]  active-high scan position, bit (7-idx)
//   frame_tick   out         one-cycle pulse after the 7->0 wrap
// ----------------------------------------------------------------------------
module anode_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits_in,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_in,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  anode_onehot,
    output logic        frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

`ifdef SCAN_BLANKING_EN
    localparam int BLANK_EFF = BLANK_CYCLES;
`else
    // Without blanking the window is zero cycles long. The parameter is still
    // referenced so that both builds have the same parameter list.
    localparam int BLANK_EFF = BLANK_CYCLES * 0;
`endif

    // Hex nibble to active-low segment pattern, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [31:0]   r_dig_sh;
    logic [7:0]    r_en_sh;
    logic [7:0]    r_dp_sh;

    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [7:0]    r_onehot;
    logic          r_ftick;

    logic          w_slot_last;
    logic          w_wrap;
    logic          w_open;
    logic          w_lit;
    logic [3:0]    w_nib;
    logic [7:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;

    assign w_slot_last = (r_cnt == CNT_LAST);
    assign w_wrap      = w_slot_last && (r_idx == 3'd7);

    // Outside the blanking window once cnt >= BLANK_EFF. The comparison is
    // written as cnt+1 > BLANK_EFF in one extra bit so that a zero-length
    // window is not a constant unsigned compare.
    assign w_open = (({1'b0, r_cnt} + (CW+1)'(1)) > (CW+1)'(BLANK_EFF));
    assign w_lit  = r_en_sh[r_idx] & w_open;
    assign w_nib  = r_dig_sh[{r_idx, 2'b00} +: 4];

    // Slot counter and scan index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (w_slot_last) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Frame snapshot of the display inputs, taken only on the 7->0 wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dig_sh <= 32'h0000_0000;
            r_en_sh  <= 8'h00;
            r_dp_sh  <= 8'h00;
        end else if (w_wrap) begin
            r_dig_sh <= digits_in;
            r_en_sh  <= digit_en;
            r_dp_sh  <= dp_in;
        end
    end

    // Next values of the pin drives for the current index and count
    always_comb begin
        w_an  = 8'hFF;
        w_seg = 7'h7F;
        w_dp  = 1'b1;
        if (w_lit) begin
            w_an  = ~(8'h01 << r_idx);
            w_seg = hex_to_seg(w_nib);
            w_dp  = ~r_dp_sh[r_idx];
        end else begin
            w_an  = 8'hFF;
            w_seg = 7'h7F;
            w_dp  = 1'b1;
        end
    end

    // Registered pin drives, one cycle behind idx/cnt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an     <= 8'hFF;
            r_seg    <= 7'h7F;
            r_dp     <= 1'b1;
            r_onehot <= 8'h00;
            r_ftick  <= 1'b0;
        end else begin
            r_an     <= w_an;
            r_seg    <= w_seg;
            r_dp     <= w_dp;
            r_onehot <= 8'h80 >> r_idx;
            r_ftick  <= w_wrap;
        end
    end

    assign an           = r_an;
    assign seg          = r_seg;
    assign dp           = r_dp;
    assign anode_onehot = r_onehot;
    assign frame_tick   = r_ftick;

endmodule

// File: tb/tb_anode_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_anode_scan_driver
//
// Directed bench for anode_scan_driver with REFRESH_DIV = 4, BLANK_CYCLES = 1.
// Output cycle n (n = 1 is the first rising edge after reset release) shows
// scan index (n-1)/4 mod 8 at slot count (n-1) mod 4. frame_tick is high when
// n is a multiple of 32. The expected shadow contents for each frame are
// written out by hand below.
// ----------------------------------------------------------------------------
module tb_anode_scan_driver;

    logic        clk;
    logic        rst;
    logic [31:0] digits_in;
    logic [7:0]  digit_en;
    logic [7:0]  dp_in;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  anode_onehot;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

`ifdef SCAN_BLANKING_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    // Expected shadow contents for the frame currently on the pins
    logic [31:0] exp_dig;
    logic [7:0]  exp_en;
    logic [7:0]  exp_dp;

    // Hand-entered active-low gfedcba patterns for 0..F
    logic [6:0] segtab [16];
    logic [7:0] onehot_tab [8];

    anode_scan_driver #(
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .digit_en    (digit_en),
        .dp_in       (dp_in),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .anode_onehot(anode_onehot),
        .frame_tick  (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp_v);
        end
    endtask

    // Turns the one-hot scan vector back into an index (anode_decoder role)
    function automatic logic [7:0] decode_onehot(input logic [7:0] oh);
        logic [7:0] r;
        r = 8'hEE;
        for (int i = 0; i < 8; i++) begin
            if (oh == (8'h80 >> i)) r = 8'(i);
        end
        return r;
    endfunction

    // Advance one clock and check every output for output cycle n
    task automatic tick_check();
        int k;
        int c;
        bit lit;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        @(posedge clk);
        @(negedge clk);
        n++;
        k   = ((n - 1) / 4) % 8;
        c   = (n - 1) % 4;
        lit = exp_en[k] && (!BLANK_ON || c >= 1);
        e_an  = lit ? ~(8'h01 << k) : 8'hFF;
        e_seg = lit ? segtab[exp_dig[4*k +: 4]] : 7'h7F;
        e_dp  = lit ? ~exp_dp[k] : 1'b1;
        chk("an", an, e_an);
        chk("seg", {1'b0, seg}, {1'b0, e_seg});
        chk("dp", {7'd0, dp}, {7'd0, e_dp});
        chk("onehot", anode_onehot, onehot_tab[k]);
        chk("decode", decode_onehot(anode_onehot), 8'(k));
        chk("frame_tick", {7'd0, frame_tick}, {7'd0, (n % 32 == 0)});
    endtask

    task automatic run_ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick_check();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_an"}, an, 8'hFF);
        chk({tag, "_seg"}, {1'b0, seg}, 8'h7F);
        chk({tag, "_dp"}, {7'd0, dp}, 8'h01);
        chk({tag, "_onehot"}, anode_onehot, 8'h00);
        chk({tag, "_ftick"}, {7'd0, frame_tick}, 8'h00);
    endtask

    initial begin
        segtab[0]  = 7'b1000000; segtab[1]  = 7'b1111001;
        segtab[2]  = 7'b0100100; segtab[3]  = 7'b0110000;
        segtab[4]  = 7'b0011001; segtab[5]  = 7'b0010010;
        segtab[6]  = 7'b0000010; segtab[7]  = 7'b1111000;
        segtab[8]  = 7'b0000000; segtab[9]  = 7'b0010000;
        segtab[10] = 7'b0001000; segtab[11] = 7'b0000011;
        segtab[12] = 7'b1000110; segtab[13] = 7'b0100001;
        segtab[14] = 7'b0000110; segtab[15] = 7'b0001110;
        onehot_tab[0] = 8'h80; onehot_tab[1] = 8'h40;
        onehot_tab[2] = 8'h20; onehot_tab[3] = 8'h10;
        onehot_tab[4] = 8'h08; onehot_tab[5] = 8'h04;
        onehot_tab[6] = 8'h02; onehot_tab[7] = 8'h01;

        // Reset held across several edges
        rst       = 1'b1;
        digits_in = 32'h7654_3210;
        digit_en  = 8'hFF;
        dp_in     = 8'h00;
        exp_dig   = 32'h0000_0000;
        exp_en    = 8'h00;
        exp_dp    = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");

        // Release: first frame dark (shadows are zero), frame_tick at n = 32
        rst = 1'b0;
        n   = 0;
        run_ticks(32);

        // Frame 2 shows 7654_3210 on all digits, no decimal points
        exp_dig = 32'h7654_3210;
        exp_en  = 8'hFF;
        exp_dp  = 8'h00;
        run_ticks(8);
        // Mid-frame input change must not reach the pins during this frame
        digits_in = 32'h0000_0A00;
        digit_en  = 8'b0000_0100;
        dp_in     = 8'b0000_0100;
        run_ticks(24);

        // Frame 3: only digit 2 lit, showing A with its decimal point
        exp_dig = 32'h0000_0A00;
        exp_en  = 8'b0000_0100;
        exp_dp  = 8'b0000_0100;
        run_ticks(32);

        // Run into slot 5 of frame 4 and reset asynchronously
        run_ticks(21);
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
        exp_dig = 32'h0000_0000;
        exp_en  = 8'h00;
        exp_dp  = 8'h00;
        run_ticks(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
